// File: rtl/spart_bus_if.sv
// SPART bus-side front end: register decode, baud divisor and tick,
// plus one-byte RX/TX buffers between the driver and the shift units.
module spart_bus_if #(
    parameter logic [15:0] DIV_RESET = 16'd651
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       baud_en
);
    typedef enum logic {IDLE, PEND} tx_state_e;

    logic        rd, wr;
    logic        rd_rx, rd_stat, wr_tx, div_wr;
    logic [7:0]  rd_data;
    logic [15:0] db_q, db_d, cnt_q;
    logic        baud_q;
    logic [7:0]  rxbuf_q, txbuf_q;
    logic        rda_q, ovr_q;
    tx_state_e   tx_state_q;

    // Divisors of 0 and 1 both collapse to a tick every cycle.
    function automatic logic [15:0] reload(input logic [15:0] div);
        return (div < 16'd2) ? 16'd0 : div - 16'd1;
    endfunction

    assign rd      = iocs & iorw;
    assign wr      = iocs & ~iorw;
    assign rd_rx   = rd & (ioaddr == 2'b00);
    assign rd_stat = rd & (ioaddr == 2'b01);
    assign wr_tx   = wr & (ioaddr == 2'b00);
    assign div_wr  = wr & ioaddr[1];

    always_comb begin
        db_d = db_q;
        if (wr && ioaddr == 2'b10) db_d[7:0]  = databus;
        if (wr && ioaddr == 2'b11) db_d[15:8] = databus;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q   <= DIV_RESET;
            cnt_q  <= reload(DIV_RESET);
            baud_q <= 1'b0;
        end else begin
            db_q <= db_d;
            if (div_wr) begin
                cnt_q  <= reload(db_d);
                baud_q <= 1'b0;
            end else if (cnt_q == 16'd0) begin
                cnt_q  <= reload(db_q);
                baud_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q - 16'd1;
                baud_q <= 1'b0;
            end
        end
    end

    // A byte arriving while the old one is read out is not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxbuf_q <= 8'h00;
            rda_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (rx_valid) begin
                rxbuf_q <= rx_data;
                rda_q   <= 1'b1;
            end else if (rd_rx) begin
                rda_q   <= 1'b0;
            end
            if (rx_valid && rda_q && !rd_rx) ovr_q <= 1'b1;
            else if (rd_stat)                ovr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            txbuf_q    <= 8'h00;
        end else begin
            unique case (tx_state_q)
                IDLE: if (wr_tx) begin
                    txbuf_q    <= databus;
                    tx_state_q <= PEND;
                end
                PEND: if (!tx_busy) tx_state_q <= IDLE;
            endcase
        end
    end

    assign tx_load = (tx_state_q == PEND) & ~tx_busy;
    assign tx_data = txbuf_q;
    assign tbr     = (tx_state_q == IDLE);
    assign rda     = rda_q;
    assign baud_en = baud_q;

    always_comb begin
        rd_data = 8'h00;
        unique case (ioaddr)
            2'b00: rd_data = rxbuf_q;
            2'b01: rd_data = {5'b0, ovr_q, tbr, rda_q};
            2'b10: rd_data = db_q[7:0];
            2'b11: rd_data = db_q[15:8];
        endcase
    end

    assign databus = rd ? rd_data : 8'hzz;
endmodule

// File: tb/tb_spart_bus_if.sv
// Bench for spart_bus_if: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_spart_bus_if;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] tb_dat = 8'h00;
    logic       tx_busy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    wire  [7:0] databus;
    wire        rda, tbr, tx_load, baud_en;
    wire  [7:0] tx_data;

    int vectors = 0;
    int errors = 0;

    assign databus = (iocs && !iorw) ? tb_dat : 8'hzz;
    pullup (databus);

    always #5 clk = ~clk;

    spart_bus_if #(.DIV_RESET(16'd651)) dut (
        .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw),
        .ioaddr(ioaddr), .databus(databus), .rda(rda), .tbr(tbr),
        .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .baud_en(baud_en)
    );

    // Behavioural model: buffered bytes, flags, and ticks since last restart.
    logic        m_rda, m_ovr, m_pend;
    logic [7:0]  m_rxbuf, m_txbuf;
    logic [15:0] m_db;
    int          m_since;

    task automatic m_reset();
        m_rda = 0; m_ovr = 0; m_pend = 0;
        m_rxbuf = 0; m_txbuf = 0;
        m_db = 16'd651; m_since = 0;
    endtask

    task automatic m_step();
        logic rd0, rd1, wr0;
        rd0 = iocs && iorw && ioaddr == 2'd0;
        rd1 = iocs && iorw && ioaddr == 2'd1;
        wr0 = iocs && !iorw && ioaddr == 2'd0;
        if (rx_valid && m_rda && !rd0) m_ovr = 1;
        else if (rd1) m_ovr = 0;
        if (rx_valid) begin
            m_rxbuf = rx_data;
            m_rda = 1;
        end else if (rd0) m_rda = 0;
        if (m_pend && !tx_busy) m_pend = 0;
        else if (!m_pend && wr0) begin
            m_pend = 1;
            m_txbuf = tb_dat;
        end
        if (iocs && !iorw && ioaddr == 2'd2) begin
            m_db[7:0] = tb_dat; m_since = 0;
        end else if (iocs && !iorw && ioaddr == 2'd3) begin
            m_db[15:8] = tb_dat; m_since = 0;
        end else m_since++;
    endtask

    function automatic logic [7:0] m_bus();
        if (iocs && iorw) begin
            case (ioaddr)
                2'd0: return m_rxbuf;
                2'd1: return {5'b0, m_ovr, !m_pend, m_rda};
                2'd2: return m_db[7:0];
                default: return m_db[15:8];
            endcase
        end
        if (iocs) return tb_dat;
        return 8'hFF;
    endfunction

    function automatic logic m_baud();
        int per;
        per = (m_db < 16'd2) ? 1 : int'(m_db);
        return m_since > 0 && (m_since % per) == 0;
    endfunction

    initial begin
        logic [19:0] e, a;
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) m_reset();
            e = {m_rda, !m_pend, m_pend && !tx_busy, m_txbuf, m_baud(), m_bus()};
            a = {rda, tbr, tx_load, tx_data, baud_en, databus};
            vectors++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle t=%0t {rda,tbr,load,txd,baud,bus}: got %h expected %h",
                         $time, a, e);
            end
            @(posedge clk);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        iocs = 1; iorw = 0; ioaddr = a; tb_dat = d;
        tick();
        iocs = 0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        iocs = 1; iorw = 1; ioaddr = a;
        #2;
        d = databus;
        tick();
        iocs = 0; iorw = 0;
    endtask

    task automatic rx(input logic [7:0] d);
        rx_valid = 1; rx_data = d;
        tick();
        rx_valid = 0;
    endtask

    task automatic wait_baud(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!baud_en && n < 2000);
    endtask

    initial begin
        logic [7:0] d;
        int n;
        repeat (3) tick();
        check("rst_tbr", tbr, 1);
        check("rst_rda", rda, 0);
        check("rst_load", tx_load, 0);
        check("rst_txdata", tx_data, 0);
        check("rst_baud", baud_en, 0);
        check("idle_bus", databus, 8'hFF);
        rst_n = 1;
        wait_baud(n);
        check("baud_first_651", n, 651);
        wait_baud(n);
        check("baud_period_651", n, 651);
        rd(2'd2, d); check("rd_db_lo_rst", d, 8'h8B);
        rd(2'd3, d); check("rd_db_hi_rst", d, 8'h02);

        wr(2'd2, 8'hA3);
        wr(2'd3, 8'h00);
        wait_baud(n);
        check("baud_first_163", n, 163);
        wait_baud(n);
        check("baud_period_163", n, 163);
        rd(2'd2, d); check("rd_db_lo", d, 8'hA3);
        rd(2'd3, d); check("rd_db_hi", d, 8'h00);

        tx_busy = 0;
        wr(2'd0, 8'h5A);
        check("tx_tbr_low", tbr, 0);
        check("tx_load_pulse", tx_load, 1);
        check("tx_data_5a", tx_data, 8'h5A);
        tick();
        check("tx_tbr_back", tbr, 1);
        check("tx_load_done", tx_load, 0);

        tx_busy = 1;
        wr(2'd0, 8'hA5);
        check("busy_tbr", tbr, 0);
        check("busy_noload", tx_load, 0);
        repeat (5) tick();
        wr(2'd0, 8'hFF);
        repeat (13) tick();
        check("busy_hold", tx_load, 0);
        tx_busy = 0;
        #1;
        check("busy_release_load", tx_load, 1);
        check("busy_release_data", tx_data, 8'hA5);
        tick();
        check("busy_tbr_back", tbr, 1);
        check("busy_drop_data", tx_data, 8'hA5);

        rx(8'h3C);
        check("rx_rda", rda, 1);
        rd(2'd1, d); check("rx_stat_before", d, 8'h03);
        rd(2'd0, d); check("rx_byte", d, 8'h3C);
        rd(2'd1, d); check("rx_stat_after", d, 8'h02);

        rx(8'h11);
        rx(8'h22);
        rd(2'd1, d); check("ovr_stat", d, 8'h07);
        rd(2'd1, d); check("ovr_cleared", d, 8'h03);
        rd(2'd0, d); check("ovr_byte", d, 8'h22);

        rx(8'h44);
        iocs = 1; iorw = 1; ioaddr = 2'd0;
        rx_valid = 1; rx_data = 8'h33;
        #2;
        check("coll_old_byte", databus, 8'h44);
        tick();
        iocs = 0; iorw = 0; rx_valid = 0;
        check("coll_rda", rda, 1);
        rd(2'd1, d); check("coll_stat", d, 8'h03);
        rd(2'd0, d); check("coll_new_byte", d, 8'h33);

        wr(2'd1, 8'hC3);
        rd(2'd1, d); check("wr01_ignored", d, 8'h02);

        tx_busy = 1;
        wr(2'd0, 8'h77);
        rx(8'h99);
        #2;
        rst_n = 0;
        #1;
        check("arst_tbr", tbr, 1);
        check("arst_rda", rda, 0);
        check("arst_load", tx_load, 0);
        check("arst_txdata", tx_data, 0);
        check("arst_baud", baud_en, 0);
        tick();
        tick();
        tx_busy = 0;
        rst_n = 1;
        tick();
        check("arst_tx_dropped", tx_load, 0);
        check("arst_rx_dropped", rda, 0);
        rd(2'd2, d); check("arst_db_lo", d, 8'h8B);

        wr(2'd2, 8'h05);
        wr(2'd3, 8'h00);
        for (int i = 0; i < 4000; i++) begin
            iocs = ($urandom_range(0, 2) == 0);
            iorw = $urandom_range(0, 1);
            ioaddr = $urandom_range(0, 3);
            tb_dat = $urandom_range(0, 255);
            if (!iorw && ioaddr[1] && $urandom_range(0, 9) != 0) iocs = 0;
            if (ioaddr == 2'd3) tb_dat = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) tx_busy = ~tx_busy;
            rx_valid = ($urandom_range(0, 5) == 0);
            rx_data = $urandom_range(0, 255);
            tick();
        end
        iocs = 0; rx_valid = 0; tx_busy = 0;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
